// File: rtl/gyro_top.sv
// Closed-loop fiber-gyro core: bias modulation, detector model, gated averaging demodulator,
// rate integrator and phase-ramp integrator. Define GYRO_INT2_WRAP_EN to build the ramp wrap.
module gyro_top #(
  parameter int unsigned POR_CYC = 16
) (
  input  logic               clk,
  output logic               o_rst_n,
  output logic               status,
  output logic               err_done,
  output logic signed [31:0] err,
  output logic signed [31:0] o_int_1,
  output logic signed [31:0] o_int_2,
  input  logic signed [31:0] err_offset,
  input  logic        [31:0] freq,
  input  logic        [2:0]  avg_sel,
  input  logic        [31:0] wait_cnt,
  input  logic               polarity,
  input  logic               gain_mode_1,
  input  logic               gain_mode_2,
  input  logic        [5:0]  gain_sel_1,
  input  logic        [5:0]  gain_sel_2,
  input  logic               zero_1,
  input  logic               zero_2,
  input  logic        [31:0] saturation_1,
  input  logic        [31:0] saturation_2,
  input  logic               add_sig_en,
  input  logic        [31:0] vth,
  input  logic               vth_mode
);

  localparam int unsigned PorW = $clog2(POR_CYC + 1);

  // Power-on reset relies on register initial values; it is the only reset source.
  logic [PorW-1:0] por_cnt_q = '0;
  logic            por_done_q = 1'b0;
  logic            rst_n;

  always_ff @(posedge clk) begin
    if (por_cnt_q != PorW'(POR_CYC)) por_cnt_q <= por_cnt_q + 1'b1;
    por_done_q <= por_done_q | (por_cnt_q == PorW'(POR_CYC - 1));
  end

  assign rst_n   = por_done_q;
  assign o_rst_n = rst_n;

  function automatic logic signed [31:0] gain(input logic signed [31:0] x, input logic mode,
                                              input logic [5:0] sel);
    if (mode) return (sel >= 6'd32) ? 32'sd0 : (x <<< sel);
    else      return (sel >= 6'd32) ? {32{x[31]}} : (x >>> sel);
  endfunction

  function automatic logic signed [35:0] sext36(input logic signed [31:0] x);
    return {{4{x[31]}}, x};
  endfunction

  // Bounds are also limited to the representable 32-bit range.
  function automatic logic signed [31:0] clamp(input logic signed [35:0] v,
                                               input logic [31:0] sat);
    logic signed [35:0] hi, lo;
    hi = (sat > 32'h7fff_ffff) ? 36'sh7fff_ffff : $signed({4'b0, sat});
    lo = (sat > 32'h8000_0000) ? -36'sh8000_0000 : -$signed({4'b0, sat});
    if (v > hi)      return 32'(hi);
    else if (v < lo) return 32'(lo);
    else             return 32'(v);
  endfunction

  logic        [31:0] hc_q, hc_d;
  logic               hc_wrap;
  logic               status_q, status_d;
  logic signed [39:0] acc_q, acc_d;
  logic signed [31:0] err_q, err_d;
  logic               done_q, done_d;
  logic signed [31:0] int1_q, int1_d, int2_q, int2_d;
  logic signed [31:0] diff, d_det, avg32;
  logic        [32:0] win_end, hc_ext;
  logic               win_ok, in_win, last_smp;

  always_comb begin
    hc_wrap  = (freq <= 32'd1) || (hc_q >= freq - 32'd1);
    hc_d     = hc_wrap ? 32'd0 : hc_q + 32'd1;
    status_d = hc_wrap ? ~status_q : status_q;
  end

  // Detector model and sampling window of the current half-period.
  always_comb begin
    diff     = err_offset - int1_q;
    d_det    = status_q ? -diff : diff;
    hc_ext   = {1'b0, hc_q};
    win_end  = {1'b0, wait_cnt} + (33'd1 << avg_sel);
    win_ok   = win_end <= {1'b0, freq};
    in_win   = (hc_ext >= {1'b0, wait_cnt}) && (hc_ext < win_end);
    last_smp = win_ok && (hc_ext == win_end - 33'd1);
    acc_d    = ((hc_q == 32'd0) ? 40'sd0 : acc_q) + (in_win ? {{8{d_det[31]}}, d_det} : 40'sd0);
    avg32    = 32'(acc_d >>> avg_sel);
    done_d   = last_smp;
    err_d    = err_q;
    if (last_smp) err_d = (status_q ^ polarity) ? -avg32 : avg32;
  end

  always_comb begin
    int1_d = int1_q;
    if (zero_1)      int1_d = 32'sd0;
    else if (done_q) int1_d = clamp(sext36(int1_q) + sext36(gain(err_q, gain_mode_1, gain_sel_1)),
                                    saturation_1);
  end

  logic signed [35:0] sum2, wrap2;

  always_comb begin
    sum2 = sext36(int2_q) + sext36(int1_q)
         + (add_sig_en ? sext36(gain(err_q, gain_mode_2, gain_sel_2)) : 36'sd0);
    wrap2 = sum2;
`ifdef GYRO_INT2_WRAP_EN
    if (vth_mode) begin
      if (sum2 >= $signed({4'b0, vth}))       wrap2 = sum2 - $signed({3'b0, vth, 1'b0});
      else if (sum2 <= -$signed({4'b0, vth})) wrap2 = sum2 + $signed({3'b0, vth, 1'b0});
    end
`endif
    int2_d = int2_q;
    if (zero_2)      int2_d = 32'sd0;
    else if (done_q) int2_d = clamp(wrap2, saturation_2);
  end

`ifndef GYRO_INT2_WRAP_EN
  logic unused_wrap_cfg;
  assign unused_wrap_cfg = ^{vth, vth_mode};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q     <= '0;
      status_q <= 1'b0;
      acc_q    <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      int1_q   <= '0;
      int2_q   <= '0;
    end else begin
      hc_q     <= hc_d;
      status_q <= status_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      done_q   <= done_d;
      int1_q   <= int1_d;
      int2_q   <= int2_d;
    end
  end

  assign status   = status_q;
  assign err_done = done_q;
  assign err      = err_q;
  assign o_int_1  = int1_q;
  assign o_int_2  = int2_q;

endmodule

// File: tb/tb_gyro_top.sv
// Directed bench for gyro_top: power-on reset, demodulator timing, integrators, gains,
// saturation, window boundary and the ramp (wrap when GYRO_INT2_WRAP_EN is defined).
module tb_gyro_top;

  logic               clk = 1'b0;
  logic               o_rst_n, status, err_done;
  logic signed [31:0] err, o_int_1, o_int_2;
  logic signed [31:0] err_offset;
  logic        [31:0] freq, wait_cnt, saturation_1, saturation_2, vth;
  logic        [2:0]  avg_sel;
  logic               polarity, gain_mode_1, gain_mode_2, zero_1, zero_2, add_sig_en, vth_mode;
  logic        [5:0]  gain_sel_1, gain_sel_2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gyro_top dut (
    .clk(clk), .o_rst_n(o_rst_n), .status(status), .err_done(err_done), .err(err),
    .o_int_1(o_int_1), .o_int_2(o_int_2), .err_offset(err_offset), .freq(freq),
    .avg_sel(avg_sel), .wait_cnt(wait_cnt), .polarity(polarity), .gain_mode_1(gain_mode_1),
    .gain_mode_2(gain_mode_2), .gain_sel_1(gain_sel_1), .gain_sel_2(gain_sel_2),
    .zero_1(zero_1), .zero_2(zero_2), .saturation_1(saturation_1),
    .saturation_2(saturation_2), .add_sig_en(add_sig_en), .vth(vth), .vth_mode(vth_mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!err_done && n < bound);
    chk("done_seen", {31'b0, err_done}, 32'd1);
  endtask

  task automatic wait_status(input int bound, output int n);
    logic s0;
    s0 = status;
    n  = 0;
    do begin
      tick();
      n++;
    end while (status == s0 && n < bound);
    chk("status_toggled", {31'b0, status}, {31'b0, ~s0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int exp2;
    err_offset = 32'sd1; freq = 32'd50; avg_sel = 3'd2; wait_cnt = 32'd10;
    polarity = 1'b0; gain_mode_1 = 1'b0; gain_mode_2 = 1'b0; gain_sel_1 = '0; gain_sel_2 = '0;
    zero_1 = 1'b0; zero_2 = 1'b0; saturation_1 = 32'd1000; saturation_2 = 32'd1000;
    add_sig_en = 1'b0; vth = 32'd10; vth_mode = 1'b1;

    // Power-on reset length and reset state.
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        chk("rst_low", {31'b0, o_rst_n}, 32'd0);
        chk("rst_status", {31'b0, status}, 32'd0);
        chk("rst_done", {31'b0, err_done}, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_int1", o_int_1, 32'd0);
        chk("rst_int2", o_int_2, 32'd0);
      end
    end while (!o_rst_n && n < 40);
    chk("por_len", n, 32'd16);

    // First demodulation and integrator update.
    wait_done(60, n);
    chk("first_done_lat", n, 32'd14);
    chk("first_err", err, 32'd1);
    chk("first_status", {31'b0, status}, 32'd0);
    tick();
    chk("done_pulse", {31'b0, err_done}, 32'd0);
    chk("int1_first", o_int_1, 32'd1);
    chk("int2_first", o_int_2, 32'd0);
    wait_status(60, n);
    chk("half_rest", n, 32'd35);
    wait_status(60, n);
    chk("half_full", n, 32'd50);
    chk("int1_hold", o_int_1, 32'd1);
    chk("int2_ramp1", o_int_2, 32'd1);

    // zero_1 forcing.
    zero_1 = 1'b1;
    tick();
    chk("zero1_now", o_int_1, 32'd0);
    wait_done(60, n);
    chk("zero1_err", err, 32'd1);
    tick();
    chk("zero1_held", o_int_1, 32'd0);
    chk("int2_zero_in", o_int_2, 32'd1);
    zero_1 = 1'b0;
    wait_done(60, n);
    chk("unzero_err", err, 32'd1);
    tick();
    chk("unzero_int1", o_int_1, 32'd1);
    chk("unzero_int2", o_int_2, 32'd1);

    // Saturation of both integrators.
    err_offset = 32'sd5000;
    wait_done(60, n);
    chk("sat_err0", err, 32'd4999);
    tick();
    chk("sat_int1a", o_int_1, 32'd1000);
    chk("sat_int2a", o_int_2, 32'd2);
    wait_done(60, n);
    chk("sat_err1", err, 32'd4000);
    tick();
    chk("sat_int1b", o_int_1, 32'd1000);
    chk("sat_int2b", o_int_2, 32'd1000);

    // Inverted polarity: runaway to -saturation_1.
    err_offset = 32'sd1; polarity = 1'b1; zero_1 = 1'b1; zero_2 = 1'b1;
    tick();
    chk("pol_z1", o_int_1, 32'd0);
    chk("pol_z2", o_int_2, 32'd0);
    zero_1 = 1'b0;
    wait_done(60, n);
    chk("pol_err0", err, -32'sd1);
    tick();
    chk("pol_int1a", o_int_1, -32'sd1);
    wait_done(60, n);
    chk("pol_err1", err, -32'sd2);
    tick();
    chk("pol_int1b", o_int_1, -32'sd3);
    for (int k = 0; k < 8; k++) begin
      wait_done(60, n);
      tick();
    end
    chk("pol_runaway", o_int_1, -32'sd1000);

    // Gain shifts.
    polarity = 1'b0; err_offset = 32'sd3; zero_1 = 1'b1; gain_mode_1 = 1'b1; gain_sel_1 = 6'd2;
    tick();
    chk("gain_z", o_int_1, 32'd0);
    zero_1 = 1'b0;
    wait_done(60, n);
    chk("gl_err0", err, 32'd3);
    tick();
    chk("gl_int1a", o_int_1, 32'd12);
    wait_done(60, n);
    chk("gl_err1", err, -32'sd9);
    tick();
    chk("gl_int1b", o_int_1, -32'sd24);
    gain_mode_1 = 1'b0; gain_sel_1 = 6'd1;
    wait_done(60, n);
    chk("gr_err", err, 32'd27);
    tick();
    chk("gr_int1", o_int_1, -32'sd11);
    gain_sel_1 = 6'd40;
    wait_done(60, n);
    chk("gr40_err", err, 32'd14);
    tick();
    chk("gr40_pos", o_int_1, -32'sd11);
    err_offset = -32'sd100;
    wait_done(60, n);
    chk("gr40_nerr", err, -32'sd89);
    tick();
    chk("gr40_neg", o_int_1, -32'sd12);

    // add_sig_en path into integrator 2; large left shift on integrator 1.
    zero_2 = 1'b0; add_sig_en = 1'b1; gain_mode_2 = 1'b1; gain_sel_2 = 6'd0;
    err_offset = -32'sd2; gain_mode_1 = 1'b1; gain_sel_1 = 6'd40;
    wait_done(60, n);
    chk("add_err", err, 32'd10);
    tick();
    chk("gl40_int1", o_int_1, -32'sd12);
    chk("add_int2", o_int_2, -32'sd2);

    // Window past the half-period: no err_done, outputs hold.
    wait_cnt = 32'd48;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (err_done) cnt++;
    end
    chk("nowin_done", cnt, 32'd0);
    chk("nowin_err", err, 32'd10);
    wait_cnt = 32'd46;
    wait_done(100, n);
    chk("edgewin_err", err, 32'd10);

    // Phase ramp with o_int_1 = 1.
    zero_1 = 1'b1; zero_2 = 1'b1; err_offset = 32'sd1; gain_mode_1 = 1'b0; gain_sel_1 = 6'd0;
    add_sig_en = 1'b0; wait_cnt = 32'd10;
    tick();
    chk("ramp_z1", o_int_1, 32'd0);
    zero_1 = 1'b0;
    wait_done(60, n);
    chk("ramp_err", err, 32'd1);
    tick();
    chk("ramp_int1", o_int_1, 32'd1);
    chk("ramp_z2", o_int_2, 32'd0);
    zero_2 = 1'b0;
    exp2 = 0;
    for (int k = 0; k < 12; k++) begin
      wait_done(60, n);
      tick();
      exp2++;
`ifdef GYRO_INT2_WRAP_EN
      if (exp2 >= 10) exp2 -= 20;
`endif
      chk("ramp_step", o_int_2, exp2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
